// File: rtl/muldiv_ctrl_if.sv
// Request handshake between the control unit and the HI/LO sequencing controller.
// The control unit is the master; muldiv_ctrl is the slave.
interface muldiv_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_ready;

    modport master (output req_valid, req_op, req_a, req_b, input req_ready);
    modport slave  (input req_valid, req_op, req_a, req_b, output req_ready);
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the MIPS HI/LO resources: issues start pulses to the
// shared multiplier/divider, waits for completion with a timeout, and owns HI/LO.
module muldiv_ctrl #(
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_ctrl_if.slave       req,
    output logic [31:0]        op_a,
    output logic [31:0]        op_b,
    output logic               mult_start,
    input  logic               mult_end,
    input  logic [31:0]        mult_hi,
    input  logic [31:0]        mult_lo,
    output logic               div_start,
    input  logic               div_end,
    input  logic [31:0]        div_hi,
    input  logic [31:0]        div_lo,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic               done,
    output logic               div_zero,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE,
        M_ISSUE,
        M_WAIT,
        D_ISSUE,
        D_WAIT,
        DONE
    } state_t;

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign req.req_ready = (state == IDLE);

    // End levels are only looked at in the WAIT states, so a stale end left high
    // by the previous operation is never mistaken for completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            err        <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        case (req.req_op)
                            OP_MULT: begin
                                op_a       <= req.req_a;
                                op_b       <= req.req_b;
                                div_zero   <= 1'b0;
                                err        <= 1'b0;
                                mult_start <= 1'b1;
                                state      <= M_ISSUE;
                            end
                            OP_DIV: begin
                                op_a <= req.req_a;
                                op_b <= req.req_b;
                                err  <= 1'b0;
                                if (req.req_b == 32'd0) begin
                                    div_zero <= 1'b1;
                                    done     <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    div_zero  <= 1'b0;
                                    div_start <= 1'b1;
                                    state     <= D_ISSUE;
                                end
                            end
                            OP_MTHI: begin
                                hi       <= req.req_a;
                                div_zero <= 1'b0;
                                err      <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end
                            OP_MTLO: begin
                                lo       <= req.req_a;
                                div_zero <= 1'b0;
                                err      <= 1'b0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                M_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= M_WAIT;
                end
                M_WAIT: begin
                    if (mult_end) begin
                        hi    <= mult_hi;
                        lo    <= mult_lo;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                D_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= D_WAIT;
                end
                D_WAIT: begin
                    if (div_end) begin
                        hi    <= div_hi;
                        lo    <= div_lo;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
